// File: rtl/cache_pkg.sv
// Shared definitions for the L2 cache: entry field positions, FSM states,
// array write operations and the reserved tag.
package cache_pkg;

  localparam int ENTRY_W  = 14;
  localparam int V_B      = 13;
  localparam int LRU_B    = 12;
  localparam int D_B      = 11;
  localparam int TAG_MSB  = 10;
  localparam int TAG_LSB  = 3;
  localparam int DATA_MSB = 2;
  localparam int DATA_LSB = 0;

  localparam logic [7:0] RSV_TAG = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WBACK,
    S_LOOKUP,
    S_EVICT,
    S_FETCH,
    S_RESPOND
  } state_t;

  typedef enum logic [1:0] {
    OP_TOUCH,
    OP_WDATA,
    OP_FILL
  } wr_op_t;

endpackage

// File: rtl/cachel2_array.sv
// 8-set x 2-way entry storage with combinational hit/victim lookup and a
// single write port for install, data update and LRU update.
module cachel2_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               hit,
  output logic               hit_way,
  output logic [DATA_W-1:0]  hit_data,
  output logic               vic_way,
  output logic               vic_valid,
  output logic               vic_dirty,
  output logic [TAG_W-1:0]   vic_tag,
  output logic [DATA_W-1:0]  vic_data,
  input  logic               wr_en,
  input  wr_op_t             wr_op,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               wr_way,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int SETS = 1 << INDEX_W;

  logic [ENTRY_W-1:0] ent [SETS][2];
  logic [ENTRY_W-1:0] e0, e1, ve;
  logic               h0, h1;

  always_comb begin
    e0        = ent[lk_idx][0];
    e1        = ent[lk_idx][1];
    h0        = e0[V_B] && (e0[TAG_MSB:TAG_LSB] == lk_tag);
    h1        = e1[V_B] && (e1[TAG_MSB:TAG_LSB] == lk_tag);
    hit       = h0 || h1;
    hit_way   = !h0;
    hit_data  = h0 ? e0[DATA_MSB:DATA_LSB] : e1[DATA_MSB:DATA_LSB];
    // At most one way carries LRU=1, so way 0's bit alone picks the victim.
    vic_way   = e0[LRU_B];
    ve        = vic_way ? e1 : e0;
    vic_valid = ve[V_B];
    vic_dirty = ve[D_B];
    vic_tag   = ve[TAG_MSB:TAG_LSB];
    vic_data  = ve[DATA_MSB:DATA_LSB];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        ent[s][0] <= '0;
        ent[s][1] <= '0;
      end
    end else if (wr_en) begin
      case (wr_op)
        OP_FILL: ent[wr_idx][wr_way] <= {1'b1, 1'b1, 1'b0, wr_tag, wr_data};
        OP_WDATA: begin
          ent[wr_idx][wr_way][DATA_MSB:DATA_LSB] <= wr_data;
          ent[wr_idx][wr_way][D_B]               <= 1'b1;
          ent[wr_idx][wr_way][LRU_B]             <= 1'b1;
        end
        default: ent[wr_idx][wr_way][LRU_B] <= 1'b1;
      endcase
      ent[wr_idx][~wr_way][LRU_B] <= 1'b0;
    end
  end

endmodule

// File: rtl/cachel2.sv
// Inclusive 2-way write-back L2: serves L1 misses, absorbs L1 write-backs,
// back-invalidates replaced lines and talks to memory over req/ack.
module cachel2
  import cache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        missin,
  input  logic [INDEX_W-1:0]          addin,
  input  logic [TAG_W+DATA_W-1:0]     datain,
  input  logic                        wback,
  input  logic [INDEX_W+TAG_W+DATA_W-1:0] wbackdata,
  output logic                        missout,
  output logic [TAG_W+DATA_W-1:0]     dataout,
  output logic                        inval,
  output logic [TAG_W+INDEX_W-1:0]    invaddr,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [TAG_W+INDEX_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int LW = TAG_W + DATA_W;
  localparam int WW = INDEX_W + LW;

  state_t              state, nstate;
  logic [INDEX_W-1:0]  req_idx, n_req_idx;
  logic [TAG_W-1:0]    req_tag, n_req_tag;
  logic [WW-1:0]       wb_cur, n_wb_cur, wb_buf;
  logic                wb_full, take_wb;

  logic                n_missout, n_inval, n_mem_req, n_mem_we;
  logic [LW-1:0]       n_dataout;
  logic [TAG_W+INDEX_W-1:0] n_invaddr, n_mem_addr;
  logic [DATA_W-1:0]   n_mem_wdata;

  logic [INDEX_W-1:0]  lk_idx, wr_idx;
  logic [TAG_W-1:0]    lk_tag, wr_tag, vic_tag;
  logic                hit, hit_way, vic_way, vic_valid, vic_dirty, wr_en, wr_way;
  logic [DATA_W-1:0]   hit_data, vic_data, wr_data;
  wr_op_t              wr_op;
  logic                unused_datain;

  assign unused_datain = ^datain[DATA_W-1:0];

  assign lk_idx = (state == S_WBACK) ? wb_cur[WW-1 -: INDEX_W] : req_idx;
  assign lk_tag = (state == S_WBACK) ? wb_cur[LW-1 -: TAG_W]   : req_tag;

  cachel2_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_array (
    .clock    (clock),
    .reset    (reset),
    .lk_idx   (lk_idx),
    .lk_tag   (lk_tag),
    .hit      (hit),
    .hit_way  (hit_way),
    .hit_data (hit_data),
    .vic_way  (vic_way),
    .vic_valid(vic_valid),
    .vic_dirty(vic_dirty),
    .vic_tag  (vic_tag),
    .vic_data (vic_data),
    .wr_en    (wr_en),
    .wr_op    (wr_op),
    .wr_idx   (wr_idx),
    .wr_way   (wr_way),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_comb begin
    nstate      = state;
    n_req_idx   = req_idx;
    n_req_tag   = req_tag;
    n_wb_cur    = wb_cur;
    take_wb     = 1'b0;
    n_missout   = 1'b1;
    n_dataout   = dataout;
    n_inval     = 1'b0;
    n_invaddr   = invaddr;
    n_mem_req   = mem_req;
    n_mem_we    = mem_we;
    n_mem_addr  = mem_addr;
    n_mem_wdata = mem_wdata;
    wr_en       = 1'b0;
    wr_op       = OP_TOUCH;
    wr_idx      = lk_idx;
    wr_way      = hit_way;
    wr_tag      = lk_tag;
    wr_data     = mem_rdata;

    case (state)
      S_IDLE: begin
        if (wb_full || wback) begin
          take_wb  = 1'b1;
          n_wb_cur = wb_full ? wb_buf : wbackdata;
          nstate   = S_WBACK;
        end else if (missin) begin
          n_req_idx = addin;
          n_req_tag = datain[LW-1 -: TAG_W];
          nstate    = S_LOOKUP;
        end
      end
      S_WBACK: begin
        if (hit) begin
          wr_en   = 1'b1;
          wr_op   = OP_WDATA;
          wr_data = wb_cur[DATA_W-1:0];
          nstate  = S_IDLE;
        end else if (!mem_req) begin
          // Line not held here: push it straight through to memory.
          n_mem_req   = 1'b1;
          n_mem_we    = 1'b1;
          n_mem_addr  = {lk_tag, lk_idx};
          n_mem_wdata = wb_cur[DATA_W-1:0];
        end else if (mem_ack) begin
          n_mem_req = 1'b0;
          n_mem_we  = 1'b0;
          nstate    = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          wr_en     = 1'b1;
          n_missout = 1'b0;
          n_dataout = {req_tag, hit_data};
          nstate    = S_RESPOND;
        end else begin
          if (vic_valid) begin
            n_inval   = 1'b1;
            n_invaddr = {vic_tag, req_idx};
          end
          n_mem_req = 1'b1;
          if (vic_valid && vic_dirty) begin
            n_mem_we    = 1'b1;
            n_mem_addr  = {vic_tag, req_idx};
            n_mem_wdata = vic_data;
            nstate      = S_EVICT;
          end else begin
            n_mem_we   = 1'b0;
            n_mem_addr = {req_tag, req_idx};
            nstate     = S_FETCH;
          end
        end
      end
      S_EVICT: begin
        if (mem_ack) begin
          n_mem_req = 1'b0;
          n_mem_we  = 1'b0;
          nstate    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!mem_req) begin
          n_mem_req  = 1'b1;
          n_mem_we   = 1'b0;
          n_mem_addr = {req_tag, req_idx};
        end else if (mem_ack) begin
          n_mem_req = 1'b0;
          // The set is untouched since LOOKUP, so vic_way is still the victim.
          if (req_tag != RSV_TAG) begin
            wr_en   = 1'b1;
            wr_op   = OP_FILL;
            wr_way  = vic_way;
            wr_tag  = req_tag;
            wr_data = mem_rdata;
          end
          n_missout = 1'b0;
          n_dataout = {req_tag, mem_rdata};
          nstate    = S_RESPOND;
        end
      end
      S_RESPOND: nstate = S_IDLE;
      default:   nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_idx   <= '0;
      req_tag   <= '0;
      wb_cur    <= '0;
      wb_buf    <= '0;
      wb_full   <= 1'b0;
      missout   <= 1'b1;
      dataout   <= '0;
      inval     <= 1'b0;
      invaddr   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= nstate;
      req_idx   <= n_req_idx;
      req_tag   <= n_req_tag;
      wb_cur    <= n_wb_cur;
      missout   <= n_missout;
      dataout   <= n_dataout;
      inval     <= n_inval;
      invaddr   <= n_invaddr;
      mem_req   <= n_mem_req;
      mem_we    <= n_mem_we;
      mem_addr  <= n_mem_addr;
      mem_wdata <= n_mem_wdata;
      if (take_wb) begin
        wb_full <= wb_full && wback;
        if (wb_full && wback) wb_buf <= wbackdata;
      end else if (wback && state != S_IDLE) begin
        wb_full <= 1'b1;
        wb_buf  <= wbackdata;
      end
    end
  end

  wback_overrun: assert property (@(posedge clock) disable iff (reset)
    !(wback && wb_full && state != S_IDLE));

endmodule
